// File: rtl/conv1x1_stream_engine.sv
// Pointwise (1x1) convolution engine: streams one pixel in, one output word per filter out.
// Optional macro RELU_EN clamps negative results to zero after rounding and saturation.
module conv1x1_stream_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned IN_CH  = 64,
    parameter int unsigned OUT_CH = 16,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cfg_we,
    input  logic [$clog2(OUT_CH*IN_CH+OUT_CH)-1:0]      cfg_addr,
    input  logic [DATA_W-1:0]                           cfg_wdata,
    output logic                                        busy,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_W-1:0]                           in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_W-1:0]                           out_data,
    output logic                                        out_last
);

    localparam int unsigned WBASE  = OUT_CH * IN_CH;
    localparam int unsigned NWORDS = WBASE + OUT_CH;
    localparam int unsigned ADDR_W = $clog2(NWORDS);
    localparam int unsigned IDX_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int unsigned KW     = $clog2(IN_CH + 1);
    localparam int unsigned OW     = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [DATA_W-1:0] mem    [NWORDS];
    logic [DATA_W-1:0] pixbuf [IN_CH];

    logic [1:0]              state, state_d;
    logic [IDX_W-1:0]        in_cnt, in_cnt_d;
    logic [OW-1:0]           o_cnt, o_cnt_d;
    logic [KW-1:0]           k_cnt, k_cnt_d;
    logic signed [ACC_W-1:0] acc, acc_d;
    logic [DATA_W-1:0]       out_data_d;
    logic                    out_valid_d, out_last_d, in_ready_d, busy_d;

    logic [IDX_W-1:0]          k_idx;
    logic [ADDR_W-1:0]         w_addr, b_addr;
    logic [OW-1:0]             bias_o;
    logic [DATA_W-1:0]         bias_word;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext, bias_acc, rnd, shf;
    logic [DATA_W-1:0]         result;

    // Weight/bias RAM: writable only while idle, never cleared by reset
    always_ff @(posedge clk) begin
        if (cfg_we && !busy && (32'(cfg_addr) < NWORDS)) begin
            mem[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            pixbuf[in_cnt] <= in_data;
        end
    end

    // Datapath: one product per MAC cycle, bias preload, round/saturate
    always_comb begin
        k_idx     = k_cnt[IDX_W-1:0];
        w_addr    = ADDR_W'(32'(o_cnt) * IN_CH + 32'(k_idx));
        bias_o    = (state == OUT) ? (o_cnt + OW'(1)) : OW'(0);
        b_addr    = ADDR_W'(WBASE + 32'(bias_o));
        bias_word = mem[b_addr];
        bias_acc  = {{(ACC_W-DATA_W){bias_word[DATA_W-1]}}, bias_word} << FRAC_W;
        prod      = $signed(pixbuf[k_idx]) * $signed(mem[w_addr]);
        prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        rnd       = acc + HALF;
        shf       = rnd >>> FRAC_W;
        if (shf > SAT_MAX) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shf < SAT_MIN) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = shf[DATA_W-1:0];
        end
`ifdef RELU_EN
        if (result[DATA_W-1]) begin
            result = '0;
        end
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state;
        in_cnt_d    = in_cnt;
        o_cnt_d     = o_cnt;
        k_cnt_d     = k_cnt;
        acc_d       = acc;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        in_ready_d  = in_ready;
        case (state)
            LOAD: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    in_cnt_d = in_cnt + IDX_W'(1);
                    if (in_cnt == IDX_W'(IN_CH - 1)) begin
                        in_cnt_d   = '0;
                        o_cnt_d    = '0;
                        k_cnt_d    = '0;
                        acc_d      = bias_acc;
                        in_ready_d = 1'b0;
                        state_d    = MAC;
                    end
                end
            end
            MAC: begin
                if (k_cnt == KW'(IN_CH)) begin
                    out_data_d  = result;
                    out_valid_d = 1'b1;
                    out_last_d  = (o_cnt == OW'(OUT_CH - 1));
                    state_d     = OUT;
                end else begin
                    acc_d   = acc + prod_ext;
                    k_cnt_d = k_cnt + KW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (o_cnt == OW'(OUT_CH - 1)) begin
                        in_cnt_d   = '0;
                        in_ready_d = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        o_cnt_d = o_cnt + OW'(1);
                        k_cnt_d = '0;
                        acc_d   = bias_acc;
                        state_d = MAC;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        busy_d = (state_d != LOAD) || (in_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            in_cnt    <= '0;
            o_cnt     <= '0;
            k_cnt     <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            in_cnt    <= in_cnt_d;
            o_cnt     <= o_cnt_d;
            k_cnt     <= k_cnt_d;
            acc       <= acc_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

endmodule
